// File: rtl/voice_mix_packer.sv
// Mixes a tlast-delimited stream of per-voice stereo samples into one gained,
// 24-bit saturated stereo beat per frame, packetised with tlast for the DMA.
module voice_mix_packer #(
  parameter int MAX_VOICES = 64,
  parameter int PKT_LEN    = 256
) (
  input  logic        axis_aclk,
  input  logic        reset,
  input  logic        s_voice_tvalid,
  output logic        s_voice_tready,
  input  logic [31:0] s_voice_tdata,
  input  logic        s_voice_tlast,
  input  logic [7:0]  master_gain,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  input  logic        clear_stats,
  output logic [15:0] clip_count,
  output logic [7:0]  voice_count
);

  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);
  localparam logic [7:0] MAX_V = 8'(MAX_VOICES);
  localparam logic signed [40:0] SAT_HI = 41'sd8388607;
  localparam logic signed [40:0] SAT_LO = -41'sd8388608;

  typedef enum logic [1:0] {
    ACCUM,
    SCALE,
    OUT
  } state_e;

  state_e             state_q, state_d;
  logic signed [31:0] accL_q, accL_d;
  logic signed [31:0] accR_q, accR_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PKT_W-1:0]   pktCnt_q, pktCnt_d;
  logic [23:0]        dataL_q, dataR_q;
  logic               tlast_q;
  logic [7:0]         voiceCount_q;
  logic [15:0]        clipCount_q;

  logic               beatFire;
  logic signed [31:0] voiceL, voiceR;
  logic signed [8:0]  gainS;
  logic signed [40:0] prodL, prodR;
  logic signed [40:0] shL, shR;
  logic [23:0]        satL, satR;
  logic               clipL, clipR;

  assign s_voice_tready = (state_q == ACCUM) && !reset;
  assign beatFire       = s_voice_tvalid && s_voice_tready;
  assign m_axis_tvalid  = (state_q == OUT);
  assign m_axis_tdata   = {{8{dataR_q[23]}}, dataR_q, {8{dataL_q[23]}}, dataL_q};
  assign m_axis_tlast   = tlast_q;
  assign clip_count     = clipCount_q;
  assign voice_count    = voiceCount_q;

  // 16-bit voice samples are promoted to the 24-bit output scale before summing.
  assign voiceL = {{8{s_voice_tdata[15]}}, s_voice_tdata[15:0], 8'h00};
  assign voiceR = {{8{s_voice_tdata[31]}}, s_voice_tdata[31:16], 8'h00};

  always_comb begin
    gainS = $signed({1'b0, master_gain});
    prodL = 41'(accL_q) * 41'(gainS);
    prodR = 41'(accR_q) * 41'(gainS);
    shL   = prodL >>> 7;
    shR   = prodR >>> 7;
    clipL = (shL > SAT_HI) || (shL < SAT_LO);
    clipR = (shR > SAT_HI) || (shR < SAT_LO);
    if (shL > SAT_HI)      satL = 24'h7FFFFF;
    else if (shL < SAT_LO) satL = 24'h800000;
    else                   satL = shL[23:0];
    if (shR > SAT_HI)      satR = 24'h7FFFFF;
    else if (shR < SAT_LO) satR = 24'h800000;
    else                   satR = shR[23:0];
  end

  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      state_q  <= ACCUM;
      accL_q   <= '0;
      accR_q   <= '0;
      cnt_q    <= '0;
      pktCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      accL_q   <= accL_d;
      accR_q   <= accR_d;
      cnt_q    <= cnt_d;
      pktCnt_q <= pktCnt_d;
    end
  end

  // Beats past the voice limit are still consumed so the frame boundary is kept.
  always_comb begin
    state_d  = state_q;
    accL_d   = accL_q;
    accR_d   = accR_q;
    cnt_d    = cnt_q;
    pktCnt_d = pktCnt_q;
    case (state_q)
      ACCUM: begin
        if (beatFire) begin
          if (cnt_q < MAX_V) begin
            accL_d = accL_q + voiceL;
            accR_d = accR_q + voiceR;
            cnt_d  = cnt_q + 8'd1;
          end
          if (s_voice_tlast) state_d = SCALE;
        end
      end
      SCALE: state_d = OUT;
      OUT: begin
        if (m_axis_tready) begin
          accL_d   = '0;
          accR_d   = '0;
          cnt_d    = '0;
          pktCnt_d = (pktCnt_q == PKT_LAST) ? '0 : pktCnt_q + PKT_W'(1);
          state_d  = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      dataL_q      <= '0;
      dataR_q      <= '0;
      tlast_q      <= 1'b0;
      voiceCount_q <= '0;
    end else if (state_q == SCALE) begin
      dataL_q      <= satL;
      dataR_q      <= satR;
      tlast_q      <= (pktCnt_q == PKT_LAST);
      voiceCount_q <= cnt_q;
    end
  end

  // One clip event per frame; a clear in the same cycle takes priority.
  always_ff @(posedge axis_aclk or posedge reset) begin
    if (reset) begin
      clipCount_q <= '0;
    end else if (clear_stats) begin
      clipCount_q <= '0;
    end else if ((state_q == SCALE) && (clipL || clipR) && (clipCount_q != 16'hFFFF)) begin
      clipCount_q <= clipCount_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_voice_mix_packer.sv
// Self-checking bench for voice_mix_packer: directed frames plus randomised
// frames compared against an arithmetic mixing model.
module tb_voice_mix_packer;

  localparam int MAXV = 5;
  localparam int PLEN = 4;

  logic        axis_aclk = 1'b0;
  logic        reset = 1'b1;
  logic        s_voice_tvalid = 1'b0;
  logic        s_voice_tready;
  logic [31:0] s_voice_tdata = '0;
  logic        s_voice_tlast = 1'b0;
  logic [7:0]  master_gain = 8'd128;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        clear_stats = 1'b0;
  logic [15:0] clip_count;
  logic [7:0]  voice_count;

  int total = 0;
  int bad = 0;

  logic signed [15:0] vL [0:15];
  logic signed [15:0] vR [0:15];
  int    frameIdx = 0;
  int    expClips = 0;
  logic [63:0] expData;
  logic        expLast;
  logic [7:0]  expVc;

  voice_mix_packer #(.MAX_VOICES(MAXV), .PKT_LEN(PLEN)) dut (
    .axis_aclk(axis_aclk), .reset(reset),
    .s_voice_tvalid(s_voice_tvalid), .s_voice_tready(s_voice_tready),
    .s_voice_tdata(s_voice_tdata), .s_voice_tlast(s_voice_tlast),
    .master_gain(master_gain),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .clear_stats(clear_stats), .clip_count(clip_count), .voice_count(voice_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mix model: sum at most MAXV voices on a x256 scale, gain/128 with floor, clamp to 24 bits.
  function automatic longint mixChannel(input longint sum, input int gain, output bit clipped);
    longint p, q;
    p = sum * gain;
    q = (p >= 0) ? p / 128 : -((-p + 127) / 128);
    clipped = 1'b0;
    if (q > 8388607) begin q = 8388607; clipped = 1'b1; end
    if (q < -8388608) begin q = -8388608; clipped = 1'b1; end
    return q;
  endfunction

  task automatic computeExpected(input int n, input int gain);
    longint sL, sR, qL, qR;
    bit cL, cR;
    sL = 0; sR = 0;
    for (int i = 0; i < n && i < MAXV; i++) begin
      sL += longint'(vL[i]) * 256;
      sR += longint'(vR[i]) * 256;
    end
    qL = mixChannel(sL, gain, cL);
    qR = mixChannel(sR, gain, cR);
    expData = {32'(qR), 32'(qL)};
    expLast = ((frameIdx % PLEN) == PLEN - 1);
    expVc   = 8'((n < MAXV) ? n : MAXV);
    if ((cL || cR) && expClips < 65535) expClips++;
  endtask

  task automatic sendBeat(input logic signed [15:0] l, input logic signed [15:0] r,
                          input logic last, input int gaps);
    int t;
    repeat (gaps) begin @(posedge axis_aclk); #1; end
    s_voice_tvalid = 1'b1;
    s_voice_tdata  = {r, l};
    s_voice_tlast  = last;
    t = 0;
    while (!s_voice_tready && t < 50) begin @(posedge axis_aclk); #1; t++; end
    if (t >= 50) checkOutput("beat_timeout", 64'(s_voice_tready), 64'd1);
    @(posedge axis_aclk); #1;
    s_voice_tvalid = 1'b0;
    s_voice_tlast  = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] gain, input int hold, input int maxGap);
    master_gain = gain;
    for (int i = 0; i < n; i++)
      sendBeat(vL[i], vR[i], i == n - 1, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    computeExpected(n, int'(gain));
    checkOutput("lat_scale_valid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("scale_ready", 64'(s_voice_tready), 64'd0);
    @(posedge axis_aclk); #1;
    checkOutput("lat_out_valid", 64'(m_axis_tvalid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge axis_aclk); #1;
      checkOutput("bp_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("bp_data", m_axis_tdata, expData);
      checkOutput("bp_last", 64'(m_axis_tlast), 64'(expLast));
      checkOutput("bp_sready", 64'(s_voice_tready), 64'd0);
    end
    checkOutput("data", m_axis_tdata, expData);
    checkOutput("last", 64'(m_axis_tlast), 64'(expLast));
    checkOutput("voice_count", 64'(voice_count), 64'(expVc));
    checkOutput("clip_count", 64'(clip_count), 64'(expClips));
    m_axis_tready = 1'b1;
    @(posedge axis_aclk); #1;
    m_axis_tready = 1'b0;
    frameIdx++;
    checkOutput("post_valid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("post_sready", 64'(s_voice_tready), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sready"}, 64'(s_voice_tready), 64'd0);
    checkOutput({tag, "_valid"}, 64'(m_axis_tvalid), 64'd0);
    checkOutput({tag, "_data"}, m_axis_tdata, 64'd0);
    checkOutput({tag, "_last"}, 64'(m_axis_tlast), 64'd0);
    checkOutput({tag, "_clip"}, 64'(clip_count), 64'd0);
    checkOutput({tag, "_vc"}, 64'(voice_count), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge axis_aclk);
    #1;
    checkResetState("rst");
    reset = 1'b0;
    #1;
    checkOutput("rst_release_sready", 64'(s_voice_tready), 64'd1);
    @(posedge axis_aclk); #1;

    vL[0] = 16'sh1000; vR[0] = -16'sd4096;
    applyStimulus(1, 8'd128, 0, 0);
    checkOutput("unity_const", expData, 64'hFFF00000_00100000);

    vL[0] = 16'sd100; vL[1] = 16'sd200; vL[2] = -16'sd50;
    vR[0] = 0; vR[1] = 0; vR[2] = 0;
    applyStimulus(3, 8'd64, 0, 0);

    for (int i = 0; i < 4; i++) begin vL[i] = 16'sh7FFF; vR[i] = -16'sd32768; end
    applyStimulus(4, 8'd255, 0, 0);
    clear_stats = 1'b1;
    @(posedge axis_aclk); #1;
    clear_stats = 1'b0;
    expClips = 0;
    checkOutput("clear_stats", 64'(clip_count), 64'd0);

    vL[0] = 16'sd1234; vR[0] = -16'sd777; vL[1] = -16'sd300; vR[1] = 16'sd20;
    applyStimulus(2, 8'd200, 10, 0);
    vL[0] = 16'sd5; vR[0] = 16'sd6;
    applyStimulus(1, 8'd0, 0, 0);

    sendBeat(16'sd999, 16'sd999, 1'b0, 0);
    sendBeat(16'sd999, 16'sd999, 1'b0, 0);
    reset = 1'b1;
    #1;
    checkResetState("midrst");
    @(posedge axis_aclk); #3;
    reset = 1'b0;
    frameIdx = 0;
    expClips = 0;
    @(posedge axis_aclk); #1;
    vL[0] = 16'sd10; vR[0] = -16'sd10;
    applyStimulus(1, 8'd128, 0, 0);

    for (int i = 0; i < 7; i++) begin vL[i] = 16'sd1; vR[i] = 16'sd0; end
    applyStimulus(7, 8'd128, 0, 0);

    for (int f = 0; f < 30; f++) begin
      int n;
      logic [7:0] g;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        vL[i] = 16'($urandom);
        vR[i] = 16'($urandom);
      end
      g = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      applyStimulus(n, g, int'($urandom_range(0, 3)), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
